// File: rtl/clock_mode_ctrl.sv
// Mode controller for the digital clock: button edges and the 1 Hz tick become
// enables/strobes for the time-of-day and timer chains. Option: CLOCK_CTRL_AUTOREPEAT_EN.
module clock_mode_ctrl #(
    parameter int ALARM_SECS    = 10,
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_sel,
    input  logic       btn_adj,
    input  logic       sec_tick,
    input  logic       timer_zero,
    output logic [1:0] rezhim,
    output logic [1:0] field,
    output logic       clock_en,
    output logic [2:0] adj_pulse,
    output logic       timer_en,
    output logic       timer_up_down,
    output logic       timer_reset_o,
    output logic       timer_adj,
    output logic       alarm
);

    typedef enum logic [1:0] {M_CLOCK, M_SETUP, M_STOPWATCH, M_COUNTDOWN} mode_e;
    typedef enum logic [1:0] {CD_IDLE, CD_RUN, CD_ALARM} cd_e;

    localparam int AW = $clog2(ALARM_SECS + 1);

    logic          btn_mode_q, btn_sel_q, btn_adj_q;
    logic          mode_edge, sel_edge, adj_edge, adj_act;
    mode_e         mode_q, mode_d;
    cd_e           cd_q, cd_d;
    logic          sw_run_q, sw_run_d;
    logic [1:0]    field_q, field_d;
    logic [AW-1:0] alarm_cnt_q, alarm_cnt_d;
    logic          clock_en_q, clock_en_d;
    logic [2:0]    adj_pulse_q, adj_pulse_d;
    logic          timer_en_q, timer_en_d;
    logic          up_down_q, up_down_d;
    logic          timer_reset_q, timer_reset_d;
    logic          timer_adj_q, timer_adj_d;
    logic          alarm_q, alarm_d;

    assign mode_edge = btn_mode & ~btn_mode_q;
    assign sel_edge  = btn_sel & ~btn_sel_q;
    assign adj_edge  = btn_adj & ~btn_adj_q;

`ifdef CLOCK_CTRL_AUTOREPEAT_EN
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          repeat_hit, rep_eligible;

    // hold_cnt_q equals cycles held since the edge; reloaded after each repeat
    always_comb begin
        rep_eligible = (mode_q == M_SETUP) || (mode_q == M_COUNTDOWN && cd_q == CD_IDLE);
        repeat_hit   = 1'b0;
        hold_cnt_d   = '0;
        if (!mode_edge && rep_eligible) begin
            if (btn_adj && hold_cnt_q != '0) begin
                if (hold_cnt_q == HW'(HOLD_CYCLES)) begin
                    repeat_hit = 1'b1;
                    hold_cnt_d = HW'(HOLD_CYCLES - REPEAT_CYCLES + 1);
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end else if (adj_edge) begin
                hold_cnt_d = HW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) hold_cnt_q <= '0;
        else        hold_cnt_q <= hold_cnt_d;
    end

    assign adj_act = adj_edge | repeat_hit;
`else
    assign adj_act = adj_edge;
`endif

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            btn_mode_q  <= 1'b0;
            btn_sel_q   <= 1'b0;
            btn_adj_q   <= 1'b0;
            mode_q      <= M_CLOCK;
            cd_q        <= CD_IDLE;
            sw_run_q    <= 1'b0;
            field_q     <= 2'd0;
            alarm_cnt_q <= '0;
        end else begin
            btn_mode_q  <= btn_mode;
            btn_sel_q   <= btn_sel;
            btn_adj_q   <= btn_adj;
            mode_q      <= mode_d;
            cd_q        <= cd_d;
            sw_run_q    <= sw_run_d;
            field_q     <= field_d;
            alarm_cnt_q <= alarm_cnt_d;
        end
    end

    // NOTE: every variable gets a default first so no latch is inferred.
    always_comb begin
        mode_d      = mode_q;
        cd_d        = cd_q;
        sw_run_d    = sw_run_q;
        field_d     = field_q;
        alarm_cnt_d = alarm_cnt_q;
        if (mode_edge) begin
            mode_d   = mode_e'(mode_q + 2'd1);
            field_d  = 2'd0;
            sw_run_d = 1'b0;
            cd_d     = CD_IDLE;
        end else begin
            case (mode_q)
                M_SETUP: if (sel_edge) field_d = (field_q == 2'd2) ? 2'd0 : field_q + 2'd1;
                M_STOPWATCH: if (sel_edge) sw_run_d = ~sw_run_q;
                M_COUNTDOWN: begin
                    case (cd_q)
                        CD_IDLE: if (sel_edge && !timer_zero) cd_d = CD_RUN;
                        CD_RUN: begin
                            if (timer_zero) begin
                                cd_d        = CD_ALARM;
                                alarm_cnt_d = '0;
                            end else if (sel_edge) begin
                                cd_d = CD_IDLE;
                            end
                        end
                        CD_ALARM: begin
                            if (sel_edge || adj_edge) begin
                                cd_d = CD_IDLE;
                            end else if (sec_tick) begin
                                if (alarm_cnt_q == AW'(ALARM_SECS - 1)) cd_d = CD_IDLE;
                                else alarm_cnt_d = alarm_cnt_q + AW'(1);
                            end
                        end
                        default: cd_d = CD_IDLE;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Enables look at the next state so a stop/alarm entry blocks a same-cycle tick
    always_comb begin
        clock_en_d    = sec_tick && (mode_d != M_SETUP);
        timer_en_d    = sec_tick && ((mode_d == M_STOPWATCH && sw_run_d) ||
                                     (mode_d == M_COUNTDOWN && cd_d == CD_RUN));
        up_down_d     = (mode_d == M_STOPWATCH) ? 1'b1 :
                        (mode_d == M_COUNTDOWN) ? 1'b0 : up_down_q;
        alarm_d       = (mode_d == M_COUNTDOWN) && (cd_d == CD_ALARM);
        timer_reset_d = mode_edge ? (mode_d == M_STOPWATCH || mode_d == M_COUNTDOWN)
                                  : (mode_q == M_STOPWATCH && !sw_run_q && adj_edge);
        timer_adj_d   = !mode_edge && mode_q == M_COUNTDOWN && cd_q == CD_IDLE && adj_act;
        adj_pulse_d   = 3'b000;
        if (!mode_edge && mode_q == M_SETUP && adj_act) begin
            case (field_q)
                2'd0:    adj_pulse_d = 3'b100;
                2'd1:    adj_pulse_d = 3'b010;
                2'd2:    adj_pulse_d = 3'b001;
                default: adj_pulse_d = 3'b000;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clock_en_q    <= 1'b0;
            adj_pulse_q   <= 3'b000;
            timer_en_q    <= 1'b0;
            up_down_q     <= 1'b1;
            timer_reset_q <= 1'b0;
            timer_adj_q   <= 1'b0;
            alarm_q       <= 1'b0;
        end else begin
            clock_en_q    <= clock_en_d;
            adj_pulse_q   <= adj_pulse_d;
            timer_en_q    <= timer_en_d;
            up_down_q     <= up_down_d;
            timer_reset_q <= timer_reset_d;
            timer_adj_q   <= timer_adj_d;
            alarm_q       <= alarm_d;
        end
    end

    assign rezhim        = mode_q;
    assign field         = field_q;
    assign clock_en      = clock_en_q;
    assign adj_pulse     = adj_pulse_q;
    assign timer_en      = timer_en_q;
    assign timer_up_down = up_down_q;
    assign timer_reset_o = timer_reset_q;
    assign timer_adj     = timer_adj_q;
    assign alarm         = alarm_q;

endmodule
